fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The parameter RESET_PC SHALL default to 32'h0000_0000 and set the PC value loaded on reset.
REQ-002 The parameter NOP_INSTR SHALL default to 32'h0000_0000 and set the InstrD value driven on a bubble.
REQ-003 Port clk SHALL be an input, 1 bit: the single clock; every register samples on its rising edge.
REQ-004 Port reset SHALL be an input, 1 bit, asynchronous and active-high.
REQ-005 Port StallF SHALL be an input, 1 bit: holds the PC and IF/ID register.
REQ-006 Port FlushD SHALL be an input, 1 bit: kills the IF/ID contents, producing a bubble.
REQ-007 Port PCSrc SHALL be an input, 1 bit: redirects fetch to BranchTarget.
REQ-008 Port BranchTarget SHALL be an input, 32 bits: the redirect address.
REQ-009 Port IMemReq SHALL be an output, 1 bit: instruction-memory request valid.
REQ-010 Port IMemAddr SHALL be an output, 32 bits: the fetch address (the PC).
REQ-011 Port IMemRdata SHALL be an input, 32 bits: the instruction word, valid when IMemReady is high.
REQ-012 Port IMemReady SHALL be an input, 1 bit: completes the request in the same cycle; zero wait states are allowed.
REQ-013 Port InstrD SHALL be an output, 32 bits: the IF/ID instruction, feeding the decoder's FullInstr.
REQ-014 Port PCPlus8D SHALL be an output, 32 bits: the fetch PC+8 paired with InstrD.
REQ-015 Port ValidD SHALL be an output, 1 bit: InstrD holds a real instruction.

Function
REQ-016 The block SHALL contain a state machine with three states: REQ (request outstanding), HOLD (word buffered while stalled) and DROP (discard an in-flight word after a redirect).
REQ-017 In REQ, IMemReq SHALL be 1; IMemAddr SHALL stay stable until IMemReady=1.
REQ-018 When IMemReady=1 and StallF=0 in REQ, the following updates SHALL occur at the next edge:
- InstrD <= IMemRdata
- PCPlus8D <= PC+8
- ValidD <= 1
- PC <= PC+4, modulo 2^32
The FSM SHALL then remain in REQ, giving a sustained rate of one instruction per cycle.
REQ-019 When IMemReady=1 and StallF=1 in REQ, the word and its PC+8 SHALL go into a one-entry skid buffer, the state SHALL move to HOLD, and PC SHALL advance by 4.
REQ-020 In HOLD, IMemReq SHALL be 0, and IF/ID SHALL keep its value while StallF=1.
REQ-021 When StallF=0 in HOLD, the skid contents SHALL load into IF/ID with ValidD=1, and the state SHALL return to REQ.
REQ-022 When IMemReady=0 in REQ, IF/ID SHALL keep its value if StallF=1; otherwise it SHALL load a bubble (NOP_INSTR, ValidD=0).
REQ-023 When PCSrc=1, the next-cycle PC SHALL be BranchTarget, taking priority over StallF and over the +4 increment.
REQ-024 When PCSrc=1 in REQ with IMemReady=1, the returned word SHALL be discarded, IF/ID SHALL get a bubble, and the state SHALL stay REQ with the new PC.
REQ-025 When PCSrc=1 in REQ with IMemReady=0, the state SHALL go to DROP.
REQ-026 In DROP, the old address SHALL be held on IMemAddr until IMemReady=1; that word SHALL be discarded, and the state SHALL return to REQ at BranchTarget, which is latched.
REQ-027 When PCSrc=1 in HOLD, the skid buffer SHALL be invalidated and the state SHALL go to REQ at BranchTarget.
REQ-028 When FlushD=1, IF/ID SHALL load a bubble at the next edge, overriding StallF and any returned word; the PC update is unaffected.
REQ-029 When PCSrc=1 and FlushD=1 together, both actions SHALL apply, with no conflict.
REQ-030 The PC SHALL be the only arithmetic state; no alignment check SHALL be made, and bits [1:0] SHALL pass through as given.

Reset
REQ-031 While reset=1, the following values SHALL be forced asynchronously:
- PC=RESET_PC
- state=REQ
- InstrD=NOP_INSTR
- PCPlus8D=0
- ValidD=0
- skid buffer invalid
REQ-032 IMemReq SHALL be 0 while reset=1, and SHALL assert in the first cycle after reset deasserts.
REQ-033 A reset during a request SHALL abandon that request; the memory SHALL be allowed to assume the request was withdrawn.

Structure
REQ-034 The package fetch_pkg SHALL hold the state enum (REQ, HOLD, DROP), RESET_PC_DEFAULT, NOP_INSTR_DEFAULT and the constant PC_INCR=4.
REQ-035 A single sub-module pc_register SHALL hold the PC with async reset, enable and load-target mux; all other logic SHALL stay in fetch_stage.

Verification
REQ-036 Zero-wait memory (IMemReady=1, memory returns its address as data), no stall, 4 cycles after reset -> InstrD sequence 0x0,0x4,0x8,0xC and PCPlus8D 0x8,0xC,0x10,0x14, with ValidD=1 each cycle.
REQ-037 StallF=1 for 3 cycles while the word at 0x8 returns -> the state enters HOLD and IMemReq=0; after release, InstrD=0x8 with no duplicate or lost word, and the next fetch is 0xC.
REQ-038 PCSrc=1 with BranchTarget=0x100 while the request at 0x10 waits 2 cycles (DROP) -> the 0x10 word is never presented on ValidD, and the next valid InstrD comes from 0x100.
REQ-039 FlushD=1 together with StallF=1 and IMemReady=1 -> next cycle ValidD=0 and InstrD=NOP_INSTR.
REQ-040 Reset asserted asynchronously mid-request at PC=0x20 -> outputs go immediately to their reset values and IMemReq=0; after release, fetch restarts at 0x0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_e     : fetch FSM states (REQ, HOLD, DROP)
//   RESET_PC_DEFAULT  : default PC loaded on reset
//   NOP_INSTR_DEFAULT : default instruction word presented on a bubble
//   PC_INCR           : sequential fetch stride in bytes
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_INCR           = 32'd4;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/pc_register.sv
// Program counter register.
//   clk, reset  : clock, asynchronous active-high reset (loads RESET_PC)
//   en          : update the PC this cycle
//   sel_target  : when enabled, load target instead of pc + PC_INCR
//   target      : redirect address
//   pc_q        : current PC
module pc_register
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        sel_target,
    input  logic [31:0] target,
    output logic [31:0] pc_q
);

    logic [31:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (en) begin
            pc_d = sel_target ? target : (pc_q + PC_INCR);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register and one-entry skid buffer.
//   clk, reset        : clock, asynchronous active-high reset
//   StallF, FlushD    : hold fetch / kill IF/ID contents
//   PCSrc, BranchTarget : redirect fetch to BranchTarget
//   IMemReq, IMemAddr : instruction memory request and address
//   IMemRdata, IMemReady : returned word, same-cycle completion
//   InstrD, PCPlus8D, ValidD : IF/ID register outputs
//
// state | meaning
// REQ   | request outstanding at the PC
// HOLD  | returned word parked in skid buffer while stalled, no request
// DROP  | redirect taken mid-request; old request held until it completes, word discarded
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        FlushD,
    input  logic        PCSrc,
    input  logic [31:0] BranchTarget,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic [31:0] IMemRdata,
    input  logic        IMemReady,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus8D,
    output logic        ValidD
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q;
    logic         pc_en;
    logic [31:0]  pc_plus8;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pcp8_q, pcp8_d;
    logic         valid_q, valid_d;
    logic [31:0]  skid_instr_q, skid_instr_d;
    logic [31:0]  skid_pcp8_q, skid_pcp8_d;
    logic         skid_valid_q, skid_valid_d;
    logic [31:0]  drop_addr_q, drop_addr_d;

    // The PC moves on a redirect, or once the current request completes;
    // a stalled completion still advances because the word goes to the skid.
    assign pc_en    = PCSrc || ((state_q == REQ) && IMemReady);
    assign pc_plus8 = pc_q + (PC_INCR << 1);

    pc_register #(.RESET_PC(RESET_PC)) u_pc (
        .clk        (clk),
        .reset      (reset),
        .en         (pc_en),
        .sel_target (PCSrc),
        .target     (BranchTarget),
        .pc_q       (pc_q)
    );

    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        pcp8_d       = pcp8_q;
        valid_d      = valid_q;
        skid_instr_d = skid_instr_q;
        skid_pcp8_d  = skid_pcp8_q;
        skid_valid_d = skid_valid_q;
        drop_addr_d  = drop_addr_q;

        case (state_q)
            REQ: begin
                if (IMemReady) begin
                    if (PCSrc) begin
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end else if (!StallF) begin
                        instr_d = IMemRdata;
                        pcp8_d  = pc_plus8;
                        valid_d = 1'b1;
                    end else begin
                        skid_instr_d = IMemRdata;
                        skid_pcp8_d  = pc_plus8;
                        skid_valid_d = 1'b1;
                        state_d      = HOLD;
                    end
                end else begin
                    if (!StallF) begin
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end
                    if (PCSrc) begin
                        // Memory still owns the old address; keep presenting it.
                        drop_addr_d = pc_q;
                        state_d     = DROP;
                    end
                end
            end
            HOLD: begin
                if (PCSrc) begin
                    skid_valid_d = 1'b0;
                    state_d      = REQ;
                    if (!StallF) begin
                        instr_d = NOP_INSTR;
                        valid_d = 1'b0;
                    end
                end else if (!StallF) begin
                    instr_d      = skid_instr_q;
                    pcp8_d       = skid_pcp8_q;
                    valid_d      = skid_valid_q;
                    skid_valid_d = 1'b0;
                    state_d      = REQ;
                end
            end
            DROP: begin
                if (!StallF) begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
                if (IMemReady) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase

        // Flush only touches IF/ID; the skid and FSM carry on as normal.
        if (FlushD) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= REQ;
            instr_q      <= NOP_INSTR;
            pcp8_q       <= 32'h0;
            valid_q      <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pcp8_q  <= 32'h0;
            skid_valid_q <= 1'b0;
            drop_addr_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            pcp8_q       <= pcp8_d;
            valid_q      <= valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pcp8_q  <= skid_pcp8_d;
            skid_valid_q <= skid_valid_d;
            drop_addr_q  <= drop_addr_d;
        end
    end

    // Gated by reset so a request in flight is withdrawn immediately.
    assign IMemReq  = !reset && ((state_q == REQ) || (state_q == DROP));
    assign IMemAddr = (state_q == DROP) ? drop_addr_q : pc_q;
    assign InstrD   = instr_q;
    assign PCPlus8D = pcp8_q;
    assign ValidD   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        StallF;
    logic        FlushD;
    logic        PCSrc;
    logic [31:0] BranchTarget;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic [31:0] IMemRdata;
    logic        IMemReady;
    logic [31:0] InstrD;
    logic [31:0] PCPlus8D;
    logic        ValidD;

    int checks = 0;
    int errors = 0;

    fetch_stage dut (
        .clk          (clk),
        .reset        (reset),
        .StallF       (StallF),
        .FlushD       (FlushD),
        .PCSrc        (PCSrc),
        .BranchTarget (BranchTarget),
        .IMemReq      (IMemReq),
        .IMemAddr     (IMemAddr),
        .IMemRdata    (IMemRdata),
        .IMemReady    (IMemReady),
        .InstrD       (InstrD),
        .PCPlus8D     (PCPlus8D),
        .ValidD       (ValidD)
    );

    // Memory returns its address as data.
    assign IMemRdata = IMemAddr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        StallF       = 1'b0;
        FlushD       = 1'b0;
        PCSrc        = 1'b0;
        BranchTarget = 32'h0;
        IMemReady    = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        StallF       = 1'b0;
        FlushD       = 1'b0;
        PCSrc        = 1'b0;
        BranchTarget = 32'h0;
        IMemReady    = 1'b1;
        step();
        checks++;
        if (IMemReq !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", IMemReq); end
        checks++;
        if (ValidD !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", ValidD); end
        checks++;
        if (InstrD !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", InstrD); end
        checks++;
        if (PCPlus8D !== 32'h0) begin errors++; $display("FAIL rst_pcp8: got %h want 0", PCPlus8D); end
        reset = 1'b0;
        #1;
        checks++;
        if (IMemReq !== 1'b1) begin errors++; $display("FAIL rst_req_after: got %b want 1", IMemReq); end
        checks++;
        if (IMemAddr !== 32'h0) begin errors++; $display("FAIL rst_addr_after: got %h want 0", IMemAddr); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] exp;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            exp = 32'(i * 4);
            checks++;
            if (InstrD !== exp) begin errors++; $display("FAIL zw_instr%0d: got %h want %h", i, InstrD, exp); end
            checks++;
            if (PCPlus8D !== exp + 32'd8) begin errors++; $display("FAIL zw_pcp8%0d: got %h want %h", i, PCPlus8D, exp + 32'd8); end
            checks++;
            if (ValidD !== 1'b1) begin errors++; $display("FAIL zw_valid%0d: got %b want 1", i, ValidD); end
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        step();
        step();
        StallF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (IMemReq !== 1'b0) begin errors++; $display("FAIL st_req%0d: got %b want 0", i, IMemReq); end
            checks++;
            if (InstrD !== 32'h4 || ValidD !== 1'b1) begin
                errors++; $display("FAIL st_keep%0d: got %h/%b want 00000004/1", i, InstrD, ValidD);
            end
        end
        StallF = 1'b0;
        step();
        checks++;
        if (InstrD !== 32'h8 || ValidD !== 1'b1) begin
            errors++; $display("FAIL st_release: got %h/%b want 00000008/1", InstrD, ValidD);
        end
        checks++;
        if (PCPlus8D !== 32'h10) begin errors++; $display("FAIL st_release_pcp8: got %h want 00000010", PCPlus8D); end
        checks++;
        if (IMemReq !== 1'b1 || IMemAddr !== 32'hC) begin
            errors++; $display("FAIL st_next_addr: got %b/%h want 1/0000000c", IMemReq, IMemAddr);
        end
        step();
        checks++;
        if (InstrD !== 32'hC || ValidD !== 1'b1) begin
            errors++; $display("FAIL st_next_word: got %h/%b want 0000000c/1", InstrD, ValidD);
        end
    endtask

    task automatic test_branch_drop();
        do_reset();
        for (int i = 0; i < 4; i++) step();
        IMemReady    = 1'b0;
        PCSrc        = 1'b1;
        BranchTarget = 32'h100;
        for (int i = 0; i < 2; i++) begin
            step();
            PCSrc = 1'b0;
            checks++;
            if (IMemReq !== 1'b1 || IMemAddr !== 32'h10) begin
                errors++; $display("FAIL drop_hold%0d: got %b/%h want 1/00000010", i, IMemReq, IMemAddr);
            end
            checks++;
            if (ValidD !== 1'b0) begin errors++; $display("FAIL drop_valid%0d: got %b want 0", i, ValidD); end
        end
        IMemReady = 1'b1;
        step();
        checks++;
        if (ValidD !== 1'b0) begin errors++; $display("FAIL drop_discard: got %b/%h want 0", ValidD, InstrD); end
        checks++;
        if (IMemAddr !== 32'h100) begin errors++; $display("FAIL drop_new_addr: got %h want 00000100", IMemAddr); end
        step();
        checks++;
        if (InstrD !== 32'h100 || ValidD !== 1'b1 || PCPlus8D !== 32'h108) begin
            errors++; $display("FAIL drop_target: got %h/%b/%h want 00000100/1/00000108", InstrD, ValidD, PCPlus8D);
        end
    endtask

    task automatic test_flush_stall();
        do_reset();
        step();
        step();
        StallF = 1'b1;
        FlushD = 1'b1;
        step();
        checks++;
        if (ValidD !== 1'b0 || InstrD !== 32'h0) begin
            errors++; $display("FAIL fl_bubble: got %b/%h want 0/00000000", ValidD, InstrD);
        end
        StallF = 1'b0;
        FlushD = 1'b0;
        step();
        checks++;
        if (InstrD !== 32'h8 || ValidD !== 1'b1) begin
            errors++; $display("FAIL fl_skid: got %h/%b want 00000008/1", InstrD, ValidD);
        end
    endtask

    task automatic test_branch_flush_ready();
        do_reset();
        step();
        PCSrc        = 1'b1;
        FlushD       = 1'b1;
        BranchTarget = 32'h40;
        step();
        PCSrc  = 1'b0;
        FlushD = 1'b0;
        checks++;
        if (ValidD !== 1'b0 || InstrD !== 32'h0) begin
            errors++; $display("FAIL bf_bubble: got %b/%h want 0/00000000", ValidD, InstrD);
        end
        checks++;
        if (IMemAddr !== 32'h40 || IMemReq !== 1'b1) begin
            errors++; $display("FAIL bf_addr: got %h/%b want 00000040/1", IMemAddr, IMemReq);
        end
        step();
        checks++;
        if (InstrD !== 32'h40 || ValidD !== 1'b1) begin
            errors++; $display("FAIL bf_target: got %h/%b want 00000040/1", InstrD, ValidD);
        end
    endtask

    task automatic test_hold_branch();
        do_reset();
        step();
        StallF = 1'b1;
        step();
        PCSrc        = 1'b1;
        BranchTarget = 32'h202;
        step();
        PCSrc = 1'b0;
        checks++;
        if (IMemReq !== 1'b1 || IMemAddr !== 32'h202) begin
            errors++; $display("FAIL hb_addr: got %b/%h want 1/00000202", IMemReq, IMemAddr);
        end
        checks++;
        if (InstrD !== 32'h0 || ValidD !== 1'b1) begin
            errors++; $display("FAIL hb_keep: got %h/%b want 00000000/1", InstrD, ValidD);
        end
        StallF = 1'b0;
        step();
        checks++;
        if (InstrD !== 32'h202 || ValidD !== 1'b1 || PCPlus8D !== 32'h20A) begin
            errors++; $display("FAIL hb_target: got %h/%b/%h want 00000202/1/0000020a", InstrD, ValidD, PCPlus8D);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (IMemAddr !== 32'h20 || InstrD !== 32'h1C) begin
            errors++; $display("FAIL ar_pre: got %h/%h want 00000020/0000001c", IMemAddr, InstrD);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (IMemReq !== 1'b0 || ValidD !== 1'b0 || InstrD !== 32'h0 || PCPlus8D !== 32'h0 || IMemAddr !== 32'h0) begin
            errors++; $display("FAIL ar_async: got req=%b v=%b i=%h p8=%h a=%h want all 0",
                               IMemReq, ValidD, InstrD, PCPlus8D, IMemAddr);
        end
        step();
        reset = 1'b0;
        step();
        checks++;
        if (InstrD !== 32'h0 || ValidD !== 1'b1 || PCPlus8D !== 32'h8) begin
            errors++; $display("FAIL ar_restart: got %h/%b/%h want 00000000/1/00000008", InstrD, ValidD, PCPlus8D);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall_hold();
        test_branch_drop();
        test_flush_stall();
        test_branch_flush_ready();
        test_hold_branch();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
